// File: rtl/led_row_scanner_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared types and board defaults for the LED matrix row scanner.
//   - scan_state_t : the two phases of a row slot (blanking gap, then drive)
//   - DEFAULT_NUM_ROWS / DEFAULT_COLS : geometry of the 8x8 board
//   - row_bits_t   : one row's worth of column bits on the 8x8 board
//   - max_int      : constant helper used to size the shared phase counter
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    localparam int DEFAULT_NUM_ROWS = 8;
    localparam int DEFAULT_COLS     = 8;

    typedef logic [DEFAULT_COLS-1:0] row_bits_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_row_scanner_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder
//   Combinational binary -> one-hot expansion, the inverse of the one-hot ->
//   binary encoder used elsewhere. With en low the output is all zero, which
//   is how the scanner keeps every row dark during blanking.
// Ports
//   bin_in      in   WIDTH       binary index
//   en          in   1           output enable
//   onehot_out  out  2**WIDTH    bit[bin_in] set when enabled, else zero
// -----------------------------------------------------------------------------
module onehot_decoder #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  en,
    output logic [(2**WIDTH)-1:0] onehot_out
);

    always_comb begin
        onehot_out = '0;
        if (en) begin
            onehot_out[bin_in] = 1'b1;
        end
    end

endmodule

// File: rtl/led_row_scanner.sv
// -----------------------------------------------------------------------------
// led_row_scanner
//   Time-multiplexes a 2**WIDTH x COLS LED matrix. Each row slot is BLANK
//   cycles with everything dark followed by DWELL cycles driving that row,
//   so the row period is BLANK+DWELL and the frame period NUM_ROWS times that.
//   A displayed (shadow) frame and one pending frame are held; a new frame
//   only replaces the displayed one at the end of the last row, so a frame is
//   never shown partially.
// Ports
//   clk          in   1              rising-edge clock
//   reset        in   1              synchronous, active-high
//   frame_valid  in   1              producer offers frame_data
//   frame_data   in   NUM_ROWS*COLS  bit [r*COLS+c] = row r, column c
//   frame_ready  out  1              pending slot is empty
//   row_sel      out  NUM_ROWS       one-hot active row, zero while blanking
//   col_data     out  COLS           columns of active row, zero while blanking
//   row_idx      out  WIDTH          current row index (blank or drive)
//   frame_start  out  1              high in the first blank cycle of row 0
// -----------------------------------------------------------------------------
module led_row_scanner
    import led_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int COLS  = DEFAULT_COLS,
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_valid,
    input  logic [(2**WIDTH)*COLS-1:0] frame_data,
    output logic                       frame_ready,
    output logic [(2**WIDTH)-1:0]      row_sel,
    output logic [COLS-1:0]            col_data,
    output logic [WIDTH-1:0]           row_idx,
    output logic                       frame_start
);

    localparam int NUM_ROWS = 2**WIDTH;
    localparam int CNT_MAX  = max_int(DWELL, BLANK);
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [WIDTH-1:0] ROW_LAST   = WIDTH'(NUM_ROWS - 1);

    scan_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     row_idx_q, row_idx_d;
    logic [COLS-1:0]      shadow_q [NUM_ROWS];
    logic [COLS-1:0]      shadow_d [NUM_ROWS];
    logic [COLS-1:0]      pending_q [NUM_ROWS];
    logic [COLS-1:0]      pending_d [NUM_ROWS];
    logic                 pending_full_q, pending_full_d;
    logic [NUM_ROWS-1:0]  row_sel_q, row_sel_d;
    logic [COLS-1:0]      col_data_q, col_data_d;
    logic                 frame_start_q, frame_start_d;

    logic                 accept;
    logic                 swap;
    logic                 drive_next;

    // One counter serves both phases: it counts up through the blanking gap,
    // restarts for the dwell, and restarts again on the way to the next row.
    // The swap is flagged only on the drive->blank edge of the last row.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        row_idx_d = row_idx_q;
        swap      = 1'b0;
        case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d   = S_BLANK;
                    cnt_d     = '0;
                    row_idx_d = row_idx_q + WIDTH'(1);
                    swap      = (row_idx_q == ROW_LAST) && pending_full_q;
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Accepting and swapping never coincide: accepting needs the pending slot
    // empty while swapping needs it full.
    always_comb begin
        accept         = frame_valid && !pending_full_q;
        pending_full_d = pending_full_q;
        pending_d      = pending_q;
        shadow_d       = shadow_q;
        if (accept) begin
            pending_full_d = 1'b1;
            for (int r = 0; r < NUM_ROWS; r++) begin
                pending_d[r] = frame_data[r*COLS +: COLS];
            end
        end else if (swap) begin
            pending_full_d = 1'b0;
            shadow_d       = pending_q;
        end
    end

    // Outputs are computed from the next state and registered, so the pins
    // only move on phase/row edges and never glitch.
    assign drive_next = (state_d == S_DRIVE);

    onehot_decoder #(
        .WIDTH (WIDTH)
    ) u_row_decoder (
        .bin_in     (row_idx_d),
        .en         (drive_next),
        .onehot_out (row_sel_d)
    );

    always_comb begin
        col_data_d    = drive_next ? shadow_d[row_idx_d] : '0;
        frame_start_d = (state_d == S_BLANK) && (cnt_d == '0) && (row_idx_d == '0);
    end

    // The reset state already is the first blank cycle of row 0, so the
    // frame_start flop loads 1 on reset; the output gate below keeps the pin
    // low while reset is still held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_BLANK;
            cnt_q          <= '0;
            row_idx_q      <= '0;
            shadow_q       <= '{default: '0};
            pending_q      <= '{default: '0};
            pending_full_q <= 1'b0;
            row_sel_q      <= '0;
            col_data_q     <= '0;
            frame_start_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            row_idx_q      <= row_idx_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            row_sel_q      <= row_sel_d;
            col_data_q     <= col_data_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign frame_ready = !pending_full_q;
    assign row_sel     = row_sel_q;
    assign col_data    = col_data_q;
    assign row_idx     = row_idx_q;
    assign frame_start = frame_start_q && !reset;

endmodule

// File: tb/tb_led_row_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_row_scanner
//   Drives the scanner with directed and random frames and compares every
//   output in every cycle against a time-based reference: the position in the
//   frame is derived from the cycle count since reset, and the displayed frame
//   follows the handshake / frame-boundary swap rules.
// -----------------------------------------------------------------------------
module tb_led_row_scanner;

    localparam int WIDTH        = 3;
    localparam int COLS         = 8;
    localparam int DWELL        = 4;
    localparam int BLANK        = 2;
    localparam int NUM_ROWS     = 8;
    localparam int ROW_PERIOD   = BLANK + DWELL;
    localparam int FRAME_PERIOD = NUM_ROWS * ROW_PERIOD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_valid = 1'b0;
    logic [63:0] frame_data = '0;
    logic        frame_ready;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic [2:0]  row_idx;
    logic        frame_start;

    led_row_scanner #(
        .WIDTH (WIDTH),
        .COLS  (COLS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ready (frame_ready),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: cycles since reset, displayed and pending frames.
    int         t = 0;
    bit         model_valid = 1'b0;
    logic [7:0] shown [NUM_ROWS];
    logic [7:0] pending [NUM_ROWS];
    bit         pend_full = 1'b0;
    bit         accepted = 1'b0;

    // Producer: holds its frame and valid until the reference says accepted.
    bit          prod_valid = 1'b0;
    logic [63:0] prod_data = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     tag, t, observed, expected);
        end
    endtask

    function automatic logic [63:0] makeFrame(input logic [7:0] base);
        logic [63:0] f;
        f = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            f[r*8 +: 8] = base | 8'(r);
        end
        return f;
    endfunction

    // Expected outputs for the current cycle from the frame position.
    task automatic checkCycle();
        int         pos;
        int         row;
        bit         blank;
        logic [7:0] e_sel;
        logic [7:0] e_col;
        pos   = t % FRAME_PERIOD;
        row   = pos / ROW_PERIOD;
        blank = (pos % ROW_PERIOD) < BLANK;
        e_sel = blank ? 8'h00 : 8'(1 << row);
        e_col = blank ? 8'h00 : shown[row];
        checkOutput("row_sel", 64'(row_sel), 64'(e_sel));
        checkOutput("col_data", 64'(col_data), 64'(e_col));
        checkOutput("row_idx", 64'(row_idx), 64'(row));
        checkOutput("frame_start", 64'(frame_start), 64'((pos == 0) && !reset));
        checkOutput("frame_ready", 64'(frame_ready), 64'(!pend_full));
        checkOutput("onehot0", 64'($onehot0(row_sel)), 64'(1));
    endtask

    // Reference update for one rising edge, using the inputs the DUT sampled.
    task automatic modelEdge();
        accepted = 1'b0;
        if (reset) begin
            t           = 0;
            model_valid = 1'b1;
            pend_full   = 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) shown[r] = 8'h00;
        end else if (model_valid) begin
            if ((t % FRAME_PERIOD) == FRAME_PERIOD - 1 && pend_full) begin
                shown     = pending;
                pend_full = 1'b0;
            end else if (frame_valid && !pend_full) begin
                for (int r = 0; r < NUM_ROWS; r++) pending[r] = frame_data[r*8 +: 8];
                pend_full = 1'b1;
                accepted  = 1'b1;
            end
            t++;
        end
    endtask

    // One cycle: apply inputs, check outputs mid-cycle, then take the edge.
    task automatic applyStimulus(input bit rst, input bit valid, input logic [63:0] data);
        reset       = rst;
        frame_valid = valid;
        frame_data  = data;
        @(negedge clk);
        if (model_valid) checkCycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic driveCycle(input bit rst);
        applyStimulus(rst, prod_valid, prod_data);
        if (accepted) prod_valid = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            shown[r]   = 8'h00;
            pending[r] = 8'h00;
        end

        // Reset for three cycles, then load frame A0|r during cycle 1.
        repeat (3) driveCycle(1'b1);
        driveCycle(1'b0);
        prod_valid = 1'b1;
        prod_data  = makeFrame(8'hA0);
        driveCycle(1'b0);

        // Offer frame 5r while pending is full; it waits for the swap.
        while (t < 20) driveCycle(1'b0);
        prod_valid = 1'b1;
        prod_data  = makeFrame(8'h50);
        while (t < 150) driveCycle(1'b0);

        // Reset in the middle of row 5's drive phase with a frame shown.
        while ((t % FRAME_PERIOD) != 32) driveCycle(1'b0);
        driveCycle(1'b1);
        while (t < 47) driveCycle(1'b0);

        // Offer a frame exactly on the row-7 drive->blank edge, pending empty.
        prod_valid = 1'b1;
        prod_data  = makeFrame(8'hC0);
        driveCycle(1'b0);
        while (t < 150) driveCycle(1'b0);

        // Random producer traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if (!prod_valid && $urandom_range(0, 9) == 0) begin
                prod_valid = 1'b1;
                prod_data  = {$urandom, $urandom};
            end
            driveCycle($urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
